// File: rtl/dport_timer_target.sv
`default_nettype none
// ==========================================================================
// Module   : dport_timer_target
// Purpose  : merlin32i data-port machine timer (64-bit time/compare, irq).
//            Optional prescaler: define DPORT_TIMER_PRESCALER_EN.
// Revision : 1.0 - initial release
// ==========================================================================
module dport_timer_target #(
  parameter logic [63:0] C_RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int          C_ADDR_BITS = 5
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        treqready_o,
  input  logic        treqvalid_i,
  input  logic        treqdvalid_i,
  input  logic [1:0]  treqsize_i,
  input  logic [31:0] treqaddr_i,
  input  logic [31:0] treqdata_i,
  input  logic        trspready_i,
  output logic        trspvalid_o,
  output logic        trsprerr_o,
  output logic        trspwerr_o,
  output logic [31:0] trspdata_o,
  output logic        irq_o
);

  localparam int OFF_W = C_ADDR_BITS - 2;
  localparam logic [OFF_W-1:0] C_OFF_TIME_LO = OFF_W'(0);
  localparam logic [OFF_W-1:0] C_OFF_TIME_HI = OFF_W'(1);
  localparam logic [OFF_W-1:0] C_OFF_CMP_LO  = OFF_W'(2);
  localparam logic [OFF_W-1:0] C_OFF_CMP_HI  = OFF_W'(3);
  localparam logic [OFF_W-1:0] C_OFF_CTRL    = OFF_W'(4);
  localparam logic [1:0]       C_SIZE_WORD   = 2'd2;

  // Architectural state
  logic [63:0] time_q, time_d;
  logic [63:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic [31:0] hi_shadow_q, hi_shadow_d;
  logic        irq_q, irq_d;

  // Response register
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_rerr_q, rsp_rerr_d;
  logic        rsp_werr_q, rsp_werr_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  // Request decode
  logic [OFF_W-1:0] off;
  logic             accept;
  logic             req_err;
  logic             wr_ok;
  logic             rd_ok;
  logic             wr_time_lo, wr_time_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
  logic             rd_time_lo;
  logic [31:0]      ctrl_rdata;
  logic [31:0]      rdata;
  logic             tick;

  assign off         = treqaddr_i[C_ADDR_BITS-1:2];
  assign treqready_o = !rsp_valid_q | trspready_i;
  assign accept      = treqvalid_i & treqready_o;
  assign req_err     = (off > C_OFF_CTRL) | (treqsize_i != C_SIZE_WORD);
  assign wr_ok       = accept & treqdvalid_i & !req_err;
  assign rd_ok       = accept & !treqdvalid_i & !req_err;

  assign wr_time_lo  = wr_ok & (off == C_OFF_TIME_LO);
  assign wr_time_hi  = wr_ok & (off == C_OFF_TIME_HI);
  assign wr_cmp_lo   = wr_ok & (off == C_OFF_CMP_LO);
  assign wr_cmp_hi   = wr_ok & (off == C_OFF_CMP_HI);
  assign wr_ctrl     = wr_ok & (off == C_OFF_CTRL);
  assign rd_time_lo  = rd_ok & (off == C_OFF_TIME_LO);

`ifdef DPORT_TIMER_PRESCALER_EN
  logic [7:0] prescale_q, prescale_d;
  logic [7:0] pcnt_q, pcnt_d;

  always_comb begin
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    tick       = en_q & (pcnt_q == prescale_q);
    if (en_q) begin
      pcnt_d = tick ? 8'h00 : pcnt_q + 8'h01;
    end
    // A CTRL write restarts the prescale period from zero
    if (wr_ctrl) begin
      prescale_d = treqdata_i[15:8];
      pcnt_d     = 8'h00;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prescale_q <= 8'h00;
      pcnt_q     <= 8'h00;
    end else begin
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end

  assign ctrl_rdata = {16'h0000, prescale_q, 7'h00, en_q};
`else
  assign tick       = en_q;
  assign ctrl_rdata = {31'h0000_0000, en_q};
`endif

  always_comb begin
    rdata = 32'h0000_0000;
    case (off)
      C_OFF_TIME_LO: rdata = time_q[31:0];
      C_OFF_TIME_HI: rdata = hi_shadow_q;
      C_OFF_CMP_LO:  rdata = cmp_q[31:0];
      C_OFF_CMP_HI:  rdata = cmp_q[63:32];
      C_OFF_CTRL:    rdata = ctrl_rdata;
      default:       rdata = 32'h0000_0000;
    endcase
  end

  always_comb begin
    time_d      = time_q;
    cmp_d       = cmp_q;
    en_d        = en_q;
    hi_shadow_d = hi_shadow_q;

    if (tick) begin
      time_d = time_q + 64'd1;
    end
    // Software writes override the increment in the same cycle
    if (wr_time_lo) begin
      time_d = {time_q[63:32], treqdata_i};
    end
    if (wr_time_hi) begin
      time_d = {treqdata_i, time_q[31:0]};
    end
    if (wr_cmp_lo) begin
      cmp_d[31:0] = treqdata_i;
    end
    if (wr_cmp_hi) begin
      cmp_d[63:32] = treqdata_i;
    end
    if (wr_ctrl) begin
      en_d = treqdata_i[0];
    end
    if (rd_time_lo) begin
      hi_shadow_d = time_q[63:32];
    end

    irq_d = en_q & (time_q >= cmp_q);
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rerr_d  = rsp_rerr_q;
    rsp_werr_d  = rsp_werr_q;
    rsp_data_d  = rsp_data_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_rerr_d  = req_err & !treqdvalid_i;
      rsp_werr_d  = req_err & treqdvalid_i;
      rsp_data_d  = rd_ok ? rdata : 32'h0000_0000;
    end else if (trspready_i) begin
      rsp_valid_d = 1'b0;
      rsp_rerr_d  = 1'b0;
      rsp_werr_d  = 1'b0;
      rsp_data_d  = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      time_q      <= 64'd0;
      cmp_q       <= C_RESET_CMP;
      en_q        <= 1'b0;
      hi_shadow_q <= 32'h0000_0000;
      irq_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rerr_q  <= 1'b0;
      rsp_werr_q  <= 1'b0;
      rsp_data_q  <= 32'h0000_0000;
    end else begin
      time_q      <= time_d;
      cmp_q       <= cmp_d;
      en_q        <= en_d;
      hi_shadow_q <= hi_shadow_d;
      irq_q       <= irq_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rerr_q  <= rsp_rerr_d;
      rsp_werr_q  <= rsp_werr_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign trspvalid_o = rsp_valid_q;
  assign trsprerr_o  = rsp_rerr_q;
  assign trspwerr_o  = rsp_werr_q;
  assign trspdata_o  = rsp_data_q;
  assign irq_o       = irq_q;

  // Address bits outside the decode window and unused data bits
  logic unused_ok;
  assign unused_ok = ^{treqaddr_i[31:C_ADDR_BITS], treqaddr_i[1:0], treqdata_i[31:1]};

endmodule
`default_nettype wire

// File: tb/tb_dport_timer_target.sv
`default_nettype none
// ==========================================================================
// Module   : tb_dport_timer_target
// Purpose  : Directed, table-driven bench for dport_timer_target.
// Revision : 1.0 - initial release
// ==========================================================================
module tb_dport_timer_target;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        treqready_o;
  logic        treqvalid_i;
  logic        treqdvalid_i;
  logic [1:0]  treqsize_i;
  logic [31:0] treqaddr_i;
  logic [31:0] treqdata_i;
  logic        trspready_i;
  logic        trspvalid_o;
  logic        trsprerr_o;
  logic        trspwerr_o;
  logic [31:0] trspdata_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

`ifdef DPORT_TIMER_PRESCALER_EN
  localparam logic [31:0] C_CTRL_RB_300 = 32'h0000_0300;
  localparam logic [31:0] C_CTRL_RB_FF  = 32'h0000_FF00;
  localparam logic [31:0] C_PRESC_TIME  = 32'd3;
`else
  localparam logic [31:0] C_CTRL_RB_300 = 32'h0000_0000;
  localparam logic [31:0] C_CTRL_RB_FF  = 32'h0000_0000;
  localparam logic [31:0] C_PRESC_TIME  = 32'd12;
`endif

  dport_timer_target dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .treqready_o  (treqready_o),
    .treqvalid_i  (treqvalid_i),
    .treqdvalid_i (treqdvalid_i),
    .treqsize_i   (treqsize_i),
    .treqaddr_i   (treqaddr_i),
    .treqdata_i   (treqdata_i),
    .trspready_i  (trspready_i),
    .trspvalid_o  (trspvalid_o),
    .trsprerr_o   (trsprerr_o),
    .trspwerr_o   (trspwerr_o),
    .trspdata_o   (trspdata_o),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_rerr;
    logic        exp_werr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // One request with immediate response acceptance; returns 1 ns after the
  // response appears, so consecutive calls are accepted on consecutive edges.
  task automatic xact(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, output logic rerr, output logic werr,
                      output logic [31:0] rd);
    treqvalid_i  = 1'b1;
    treqdvalid_i = wr;
    treqsize_i   = sz;
    treqaddr_i   = addr;
    treqdata_i   = wd;
    trspready_i  = 1'b1;
    cyc();
    treqvalid_i  = 1'b0;
    treqdvalid_i = 1'b0;
    chk("rsp_valid_latency", trspvalid_o, 1);
    rerr = trsprerr_o;
    werr = trspwerr_o;
    rd   = trspdata_o;
  endtask

  task automatic wr32(input logic [31:0] addr, input logic [31:0] wd);
    logic re, we;
    logic [31:0] d;
    xact(1'b1, 2'd2, addr, wd, re, we, d);
    chk("write_werr", we, 0);
  endtask

  task automatic rd32(input logic [31:0] addr, output logic [31:0] d);
    logic re, we;
    xact(1'b0, 2'd2, addr, 32'h0, re, we, d);
    chk("read_rerr", re, 0);
  endtask

  task automatic do_reset();
    reset_i      = 1'b1;
    treqvalid_i  = 1'b0;
    treqdvalid_i = 1'b0;
    treqsize_i   = 2'd2;
    treqaddr_i   = 32'h0;
    treqdata_i   = 32'h0;
    trspready_i  = 1'b1;
    repeat (2) @(posedge clk_i);
    #3;
    reset_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic re, we;
    logic [31:0] d, lo0, hi0, lo1, hi1;
    int rise;

    vecs[0]  = '{1'b0, 2'd2, 32'h08, 32'h0,         1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[1]  = '{1'b0, 2'd2, 32'h0C, 32'h0,         1'b0, 1'b0, 32'hFFFF_FFFF};
    vecs[2]  = '{1'b0, 2'd2, 32'h10, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 2'd2, 32'h00, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 2'd2, 32'h08, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 2'd2, 32'h0C, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 2'd2, 32'h08, 32'h0,         1'b0, 1'b0, 32'h1234_5678};
    vecs[7]  = '{1'b0, 2'd2, 32'h0C, 32'h0,         1'b0, 1'b0, 32'h9ABC_DEF0};
    vecs[8]  = '{1'b1, 2'd0, 32'h08, 32'h0000_DEAD, 1'b0, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 2'd2, 32'h08, 32'h0,         1'b0, 1'b0, 32'h1234_5678};
    vecs[10] = '{1'b0, 2'd1, 32'h0C, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 2'd2, 32'h14, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 2'd2, 32'h18, 32'h5,         1'b0, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 2'd2, 32'h1C, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 2'd2, 32'h04, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 2'd2, 32'h00, 32'hAAAA_5555, 1'b0, 1'b0, 32'h0};
    vecs[16] = '{1'b1, 2'd2, 32'h04, 32'h7,         1'b0, 1'b0, 32'h0};
    vecs[17] = '{1'b0, 2'd2, 32'h04, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[18] = '{1'b0, 2'd2, 32'h00, 32'h0,         1'b0, 1'b0, 32'hAAAA_5555};
    vecs[19] = '{1'b0, 2'd2, 32'h04, 32'h0,         1'b0, 1'b0, 32'h7};
    vecs[20] = '{1'b1, 2'd2, 32'h10, 32'h0000_0300, 1'b0, 1'b0, 32'h0};
    vecs[21] = '{1'b0, 2'd2, 32'h10, 32'h0,         1'b0, 1'b0, C_CTRL_RB_300};
    vecs[22] = '{1'b0, 2'd2, 32'h4000_0008, 32'h0,  1'b0, 1'b0, 32'h1234_5678};
    vecs[23] = '{1'b0, 2'd2, 32'h00, 32'h0,         1'b0, 1'b0, 32'hAAAA_5555};
    vecs[24] = '{1'b1, 2'd2, 32'h10, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0};
    vecs[25] = '{1'b0, 2'd2, 32'h10, 32'h0,         1'b0, 1'b0, C_CTRL_RB_FF};

    // Reset state
    do_reset();
    chk("reset_trspvalid", trspvalid_o, 0);
    chk("reset_trsprerr", trsprerr_o, 0);
    chk("reset_trspwerr", trspwerr_o, 0);
    chk("reset_trspdata", trspdata_o, 0);
    chk("reset_irq", irq_o, 0);
    chk("reset_treqready", treqready_o, 1);

    // Register map and error vectors (EN stays 0 so time is static)
    for (int i = 0; i < 26; i++) begin
      xact(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, re, we, d);
      chk($sformatf("vec%0d_rerr", i), re, vecs[i].exp_rerr);
      chk($sformatf("vec%0d_werr", i), we, vecs[i].exp_werr);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
    end

    // Counting from EN: write accepted at E0, read accepted at E11 sees 10
    do_reset();
    wr32(32'h10, 32'h1);
    repeat (10) cyc();
    rd32(32'h00, d);
    chk("count_10", d, 32'd10);

    // Carry across the 32-bit boundary with a coherent hi shadow
    wr32(32'h10, 32'h0);
    wr32(32'h00, 32'hFFFF_FFFE);
    wr32(32'h04, 32'h0);
    wr32(32'h10, 32'h1);
    rd32(32'h00, lo0);
    rd32(32'h04, hi0);
    rd32(32'h00, lo1);
    rd32(32'h04, hi1);
    chk("carry_lo0", lo0, 32'hFFFF_FFFE);
    chk("carry_hi0", hi0, 32'h0);
    chk("carry_lo1", lo1, 32'h0);
    chk("carry_hi1", hi1, 32'h1);

    // Interrupt rises one cycle after time reaches compare
    do_reset();
    wr32(32'h0C, 32'h0);
    wr32(32'h08, 32'd20);
    wr32(32'h10, 32'h1);
    rise = -1;
    for (int k = 1; k <= 100; k++) begin
      cyc();
      if (irq_o === 1'b1) begin
        rise = k;
        break;
      end
    end
    chk("irq_rise_cycle", rise, 21);
    wr32(32'h08, 32'd1000);
    chk("irq_still_high_at_cmp_write", irq_o, 1);
    cyc();
    chk("irq_fall", irq_o, 0);

    // Stall: response held, no second accept, then pop+accept in one edge
    treqvalid_i  = 1'b1;
    treqdvalid_i = 1'b0;
    treqsize_i   = 2'd2;
    treqaddr_i   = 32'h08;
    trspready_i  = 1'b0;
    cyc();
    chk("stall_valid0", trspvalid_o, 1);
    chk("stall_data0", trspdata_o, 32'd1000);
    treqaddr_i = 32'h0C;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("stall_valid_%0d", k), trspvalid_o, 1);
      chk($sformatf("stall_data_%0d", k), trspdata_o, 32'd1000);
      chk($sformatf("stall_ready_%0d", k), treqready_o, 0);
    end
    trspready_i = 1'b1;
    #1;
    chk("release_ready", treqready_o, 1);
    cyc();
    treqvalid_i = 1'b0;
    chk("release_valid", trspvalid_o, 1);
    chk("release_data", trspdata_o, 32'h0);
    chk("release_rerr", trsprerr_o, 0);
    cyc();
    chk("release_drain", trspvalid_o, 0);

    // Reset during a pending response
    treqvalid_i  = 1'b1;
    treqdvalid_i = 1'b0;
    treqaddr_i   = 32'h00;
    trspready_i  = 1'b0;
    cyc();
    chk("pend_valid", trspvalid_o, 1);
    treqvalid_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    chk("async_reset_valid", trspvalid_o, 0);
    chk("async_reset_data", trspdata_o, 0);
    cyc();
    reset_i     = 1'b0;
    trspready_i = 1'b1;
    cyc();
    chk("post_reset_no_rsp", trspvalid_o, 0);
    rd32(32'h00, d);
    chk("post_reset_time", d, 32'h0);
    rd32(32'h0C, d);
    chk("post_reset_cmp_hi", d, 32'hFFFF_FFFF);
    rd32(32'h10, d);
    chk("post_reset_ctrl", d, 32'h0);

    // Prescale 3: time steps every 4 cycles (every cycle without prescaler)
    do_reset();
    wr32(32'h10, 32'h0000_0301);
    repeat (12) cyc();
    rd32(32'h00, d);
    chk("prescale_time", d, C_PRESC_TIME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
